// File: rtl/muldiv_dispatch.sv
// Serializes one full-warp mul/div request into NUM_LANES-wide packets.
// Optional MULDIV_PACKET_SKIP_EN: skip packets whose tmask slice is empty.
module muldiv_dispatch #(
    parameter int NUM_THREADS = 4,
    parameter int NUM_LANES   = 1,
    parameter int XLEN        = 32,
    parameter int UUID_WIDTH  = 44,
    parameter int NW_WIDTH    = 2,
    parameter int NR_BITS     = 5,
    parameter int OP_BITS     = 4,
    parameter int MOD_BITS    = 3,
    localparam int NUM_PACKETS = NUM_THREADS / NUM_LANES,
    localparam int PID_WIDTH   = (NUM_PACKETS > 1) ? $clog2(NUM_PACKETS) : 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [UUID_WIDTH-1:0]       in_uuid,
    input  logic [NW_WIDTH-1:0]         in_wid,
    input  logic [NUM_THREADS-1:0]      in_tmask,
    input  logic [XLEN-1:0]             in_PC,
    input  logic [NR_BITS-1:0]          in_rd,
    input  logic                        in_wb,
    input  logic [OP_BITS-1:0]          in_op_type,
    input  logic [MOD_BITS-1:0]         in_op_mod,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
    input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [UUID_WIDTH-1:0]       out_uuid,
    output logic [NW_WIDTH-1:0]         out_wid,
    output logic [NUM_LANES-1:0]        out_tmask,
    output logic [XLEN-1:0]             out_PC,
    output logic [NR_BITS-1:0]          out_rd,
    output logic                        out_wb,
    output logic [OP_BITS-1:0]          out_op_type,
    output logic [MOD_BITS-1:0]         out_op_mod,
    output logic [NUM_LANES*XLEN-1:0]   out_rs1_data,
    output logic [NUM_LANES*XLEN-1:0]   out_rs2_data,
    output logic [PID_WIDTH-1:0]        out_pid,
    output logic                        out_sop,
    output logic                        out_eop
);

    localparam int SLICE_W = NUM_LANES * XLEN;
    localparam logic [PID_WIDTH-1:0] LAST_PID = PID_WIDTH'(NUM_PACKETS - 1);

    typedef enum logic {IDLE, SEND} state_t;

    state_t                      state;
    logic [PID_WIDTH-1:0]        pid;
    logic [PID_WIDTH-1:0]        start_pid;
    logic [PID_WIDTH-1:0]        next_pid;
    logic [PID_WIDTH-1:0]        first_pid;
    logic [PID_WIDTH-1:0]        last_pid;
    logic [NUM_THREADS-1:0]      tmask;
    logic [NUM_THREADS*XLEN-1:0] rs1;
    logic [NUM_THREADS*XLEN-1:0] rs2;
    logic                        out_fire;
    logic                        in_fire;

`ifdef MULDIV_PACKET_SKIP_EN
    function automatic logic slice_nz(
        input logic [NUM_THREADS-1:0] m,
        input int                     k
    );
        return |m[k*NUM_LANES +: NUM_LANES];
    endfunction

    // An all-zero mask resolves to pid 0 so the warp still commits once.
    function automatic logic [PID_WIDTH-1:0] first_nz(
        input logic [NUM_THREADS-1:0] m
    );
        logic [PID_WIDTH-1:0] r;
        r = '0;
        for (int k = NUM_PACKETS - 1; k >= 0; k--) begin
            if (slice_nz(m, k)) r = PID_WIDTH'(k);
        end
        return r;
    endfunction

    function automatic logic [PID_WIDTH-1:0] last_nz(
        input logic [NUM_THREADS-1:0] m
    );
        logic [PID_WIDTH-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_PACKETS; k++) begin
            if (slice_nz(m, k)) r = PID_WIDTH'(k);
        end
        return r;
    endfunction

    function automatic logic [PID_WIDTH-1:0] next_nz(
        input logic [NUM_THREADS-1:0] m,
        input logic [PID_WIDTH-1:0]   p
    );
        logic [PID_WIDTH-1:0] r;
        r = p;
        for (int k = NUM_PACKETS - 1; k >= 0; k--) begin
            if (k > int'(p) && slice_nz(m, k)) r = PID_WIDTH'(k);
        end
        return r;
    endfunction

    always_comb begin
        start_pid = first_nz(in_tmask);
        first_pid = first_nz(tmask);
        last_pid  = last_nz(tmask);
        next_pid  = next_nz(tmask, pid);
    end
`else
    always_comb begin
        start_pid = '0;
        first_pid = '0;
        last_pid  = LAST_PID;
        next_pid  = pid + PID_WIDTH'(1);
    end
`endif

    assign out_fire = out_valid && out_ready;
    assign out_sop  = (pid == first_pid);
    assign out_eop  = (pid == last_pid);
    assign out_pid  = pid;
    assign in_ready = (state == IDLE) || (out_fire && out_eop);
    assign in_fire  = in_valid && in_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            pid       <= '0;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        state     <= SEND;
                        pid       <= start_pid;
                        out_valid <= 1'b1;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (!out_eop) begin
                            pid <= next_pid;
                        end else if (in_valid) begin
                            pid <= start_pid;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    // Payload is don't-care while idle, so it carries no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            out_uuid    <= in_uuid;
            out_wid     <= in_wid;
            out_PC      <= in_PC;
            out_rd      <= in_rd;
            out_wb      <= in_wb;
            out_op_type <= in_op_type;
            out_op_mod  <= in_op_mod;
            tmask       <= in_tmask;
            rs1         <= in_rs1_data;
            rs2         <= in_rs2_data;
        end
    end

    always_comb begin
        out_tmask    = '0;
        out_rs1_data = '0;
        out_rs2_data = '0;
        for (int k = 0; k < NUM_PACKETS; k++) begin
            if (pid == PID_WIDTH'(k)) begin
                out_tmask    = tmask[k*NUM_LANES +: NUM_LANES];
                out_rs1_data = rs1[k*SLICE_W +: SLICE_W];
                out_rs2_data = rs2[k*SLICE_W +: SLICE_W];
            end
        end
    end

endmodule

// File: doc/muldiv_dispatch.md
Name: muldiv_dispatch

Overview:
- Issue-side initiator for the mul/div execute unit; drives its execute interface.
- Accepts one full-warp request per handshake: all NUM_THREADS lanes of rs1/rs2 plus tag.
- Serializes the request into NUM_PACKETS = NUM_THREADS/NUM_LANES lane packets, each with pid/sop/eop, for the NUM_LANES-wide mul/div datapath.
- Sits between the operand-collect stage and the mul/div unit, one instance per mul/div unit.

Parameters:
- NUM_THREADS, 4: warp width; must be a multiple of NUM_LANES.
- NUM_LANES, 1: lanes per issued packet.
- XLEN, 32: data width, 32 or 64.
- UUID_WIDTH, 44: instruction uuid width.
- NW_WIDTH, 2: warp-id width.
- NR_BITS, 5: register index width.
- OP_BITS, 4: op_type width.
- MOD_BITS, 3: op_mod width.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  warp request valid.
- in_ready  out  1  warp request accepted.
- in_uuid  in  UUID_WIDTH  instruction uuid.
- in_wid  in  NW_WIDTH  warp id.
- in_tmask  in  NUM_THREADS  thread mask.
- in_PC  in  XLEN  instruction PC.
- in_rd  in  NR_BITS  destination register.
- in_wb  in  1  writeback enable.
- in_op_type  in  OP_BITS  M-extension op.
- in_op_mod  in  MOD_BITS  op modifier (W variants).
- in_rs1_data  in  NUM_THREADS*XLEN  operand A, lane i at [i*XLEN +: XLEN].
- in_rs2_data  in  NUM_THREADS*XLEN  operand B, same layout.
- out_valid  out  1  packet valid.
- out_ready  in  1  mul/div unit accepts packet.
- out_uuid / out_wid / out_PC / out_rd / out_wb / out_op_type / out_op_mod  out  (as inputs)  captured tag, constant for all packets of a warp.
- out_tmask  out  NUM_LANES  tmask slice for the current pid.
- out_rs1_data  out  NUM_LANES*XLEN  operand A slice for the current pid.
- out_rs2_data  out  NUM_LANES*XLEN  operand B slice for the current pid.
- out_pid  out  PID_WIDTH  packet index; PID_WIDTH = max(1, clog2(NUM_PACKETS)).
- out_sop  out  1  first packet of the warp.
- out_eop  out  1  last packet of the warp.

Behaviour:
- Definitions: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- Reset (async assert, sync release):
  - out_valid = 0, pid = 0, state = IDLE, in_ready = 1.
  - Payload registers are not reset; out_* data is don't-care while out_valid = 0.
- State IDLE:
  - in_ready = 1, out_valid = 0.
  - On in_fire: capture the whole request, set pid = 0, go to SEND.
- State SEND:
  - out_valid = 1.
  - Slice k = pid: tmask[k*NUM_LANES +: NUM_LANES]; rs1/rs2 use the same lane range.
  - out_sop = (pid == first); out_eop = (pid == last).
  - On out_fire with !eop: pid increments by 1.
  - On out_fire with eop: if in_fire in the same cycle, recapture, pid = 0, stay in SEND; otherwise go to IDLE.
- in_ready = (state == IDLE) || (out_fire && out_eop). This gives zero-bubble back-to-back warps.
- Latency: in_fire at cycle t gives out_valid with pid 0 at t+1. A warp takes at least NUM_PACKETS cycles.
- Out payload is stable while out_valid && !out_ready; no output field changes until out_fire.
- NUM_PACKETS == 1: pid is always 0, sop = eop = 1, and the block behaves as a 1-entry pipeline register with full throughput.
- The block does not modify op_type, op_mod or operand values; W-variant handling stays in the mul/div unit.

Optional Feature:
- Macro: MULDIV_PACKET_SKIP_EN.
- Defined:
  - Packets whose tmask slice is all zero are not emitted; pid advances directly to the next non-zero slice.
  - Each step is 1 cycle, computed combinationally by a priority-encode over the remaining slices.
  - sop marks the first emitted packet; eop marks the last non-zero slice.
  - If in_tmask is all zero: exactly one packet with pid 0, sop = eop = 1 and tmask 0, so the commit still occurs.
- Undefined: every pid 0..NUM_PACKETS-1 is emitted, regardless of tmask.

Test Plan:
- Reset, single warp (NUM_THREADS=4, NUM_LANES=1, tmask=4'b1111, rs1 lanes = 1,2,3,4; out_ready=1) -> pids 0,1,2,3 on consecutive cycles; rs1 = 1,2,3,4; sop only on pid 0, eop only on pid 3; in_ready=0 during pids 0-2.
- Backpressure: out_ready=0 for 3 cycles at pid 1 -> pid, data, sop and eop held constant; resumes pid 2 after out_ready=1.
- Back-to-back: second warp valid during pid 3 with out_ready=1 -> in_ready=1 on the eop cycle, next cycle pid 0 of warp 2 (no bubble).
- Skip, macro defined: tmask=4'b0101 -> packets pid 0 (sop) and pid 2 (eop) only. Macro undefined -> 4 packets, pid 1 and pid 3 with tmask 0.
- All-zero tmask with macro defined -> one packet, pid 0, sop=eop=1.
- Async reset asserted mid-warp at pid 2 -> out_valid=0 immediately without a clock; after release in_ready=1, pid=0, no stale packet emitted.
